// File: rtl/lsu_store_bus_if.sv
// rtl/lsu_store_bus_if.sv - req/gnt/rvalid write bus between the store master and data memory
interface lsu_store_bus_if;
  logic        data_req_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic        data_err_i;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;

  modport master (
    output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_err_i
  );

  modport slave (
    input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_err_i
  );
endinterface

// File: rtl/lsu_store_bus.sv
// rtl/lsu_store_bus.sv - store-side data bus master; define MISALIGNED_SPLIT_EN to split word-crossing stores
// Without MISALIGNED_SPLIT_EN a word-crossing store completes with an error and never touches the bus.
module lsu_store_bus (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   st_valid_i,
  output logic                   st_ready_o,
  input  logic [31:0]            st_addr_i,
  input  logic [31:0]            st_wdata_i,
  input  logic                   st_sb_i,
  input  logic                   st_sh_i,
  output logic                   st_done_o,
  output logic                   st_err_o,
  lsu_store_bus_if.master        bus
);

  typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, FAULT} state_e;

  state_e      state_q;
  logic        req_q;
  logic [31:0] bus_addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;

  logic [3:0]  mask_d;
  logic [7:0]  be8_d;
  logic        split_d;
  logic [31:0] lo_wdata_d;
  logic        accept;
  logic        last_beat;

`ifdef MISALIGNED_SPLIT_EN
  logic [63:0] wd64_d;
  logic [31:0] hi_wdata_d;
  logic [31:0] base_addr_q;
  logic [3:0]  hi_be_q;
  logic [31:0] hi_wdata_q;
  logic        split_q;
`endif

  // Lane placement of the right-aligned store; bytes past lane 3 spill into the next word.
  always_comb begin
    mask_d = 4'b1111;
    if (st_sb_i && !st_sh_i) begin
      mask_d = 4'b0001;
    end else if (st_sh_i && !st_sb_i) begin
      mask_d = 4'b0011;
    end
    be8_d   = {4'b0000, mask_d} << st_addr_i[1:0];
    split_d = |be8_d[7:4];
`ifdef MISALIGNED_SPLIT_EN
    wd64_d     = {32'b0, st_wdata_i} << {st_addr_i[1:0], 3'b000};
    lo_wdata_d = wd64_d[31:0];
    hi_wdata_d = wd64_d[63:32];
`else
    lo_wdata_d = st_wdata_i << {st_addr_i[1:0], 3'b000};
`endif
  end

  assign accept = st_valid_i && (state_q == IDLE);

`ifdef MISALIGNED_SPLIT_EN
  assign last_beat = !split_q;
`else
  assign last_beat = 1'b1;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      bus_addr_q  <= 32'b0;
      be_q        <= 4'b0;
      wdata_q     <= 32'b0;
`ifdef MISALIGNED_SPLIT_EN
      base_addr_q <= 32'b0;
      hi_be_q     <= 4'b0;
      hi_wdata_q  <= 32'b0;
      split_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
`ifdef MISALIGNED_SPLIT_EN
            base_addr_q <= {st_addr_i[31:2], 2'b00};
            hi_be_q     <= be8_d[7:4];
            hi_wdata_q  <= hi_wdata_d;
            split_q     <= split_d;
            state_q     <= REQ1;
            req_q       <= 1'b1;
            bus_addr_q  <= {st_addr_i[31:2], 2'b00};
            be_q        <= be8_d[3:0];
            wdata_q     <= lo_wdata_d;
`else
            if (split_d) begin
              state_q <= FAULT;
            end else begin
              state_q    <= REQ1;
              req_q      <= 1'b1;
              bus_addr_q <= {st_addr_i[31:2], 2'b00};
              be_q       <= be8_d[3:0];
              wdata_q    <= lo_wdata_d;
            end
`endif
          end
        end
        REQ1: begin
          if (bus.data_gnt_i) begin
            state_q    <= WAIT1;
            req_q      <= 1'b0;
            bus_addr_q <= 32'b0;
            be_q       <= 4'b0;
            wdata_q    <= 32'b0;
          end
        end
        WAIT1: begin
          if (bus.data_rvalid_i) begin
            if (bus.data_err_i || last_beat) begin
              state_q <= IDLE;
            end else begin
`ifdef MISALIGNED_SPLIT_EN
              state_q    <= REQ2;
              req_q      <= 1'b1;
              bus_addr_q <= base_addr_q + 32'd4;
              be_q       <= hi_be_q;
              wdata_q    <= hi_wdata_q;
`else
              state_q <= IDLE;
`endif
            end
          end
        end
`ifdef MISALIGNED_SPLIT_EN
        REQ2: begin
          if (bus.data_gnt_i) begin
            state_q    <= WAIT2;
            req_q      <= 1'b0;
            bus_addr_q <= 32'b0;
            be_q       <= 4'b0;
            wdata_q    <= 32'b0;
          end
        end
        WAIT2: begin
          if (bus.data_rvalid_i) begin
            state_q <= IDLE;
          end
        end
`endif
        FAULT: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Completion is combinational so the pipeline sees it in the response cycle.
  always_comb begin
    st_done_o = 1'b0;
    st_err_o  = 1'b0;
    case (state_q)
      WAIT1: begin
        if (bus.data_rvalid_i) begin
          st_done_o = bus.data_err_i || last_beat;
          st_err_o  = bus.data_err_i;
        end
      end
`ifdef MISALIGNED_SPLIT_EN
      WAIT2: begin
        if (bus.data_rvalid_i) begin
          st_done_o = 1'b1;
          st_err_o  = bus.data_err_i;
        end
      end
`endif
      FAULT: begin
        st_done_o = 1'b1;
        st_err_o  = 1'b1;
      end
      default: begin
        st_done_o = 1'b0;
        st_err_o  = 1'b0;
      end
    endcase
  end

  assign st_ready_o       = (state_q == IDLE);
  assign bus.data_req_o   = req_q;
  assign bus.data_we_o    = req_q;
  assign bus.data_addr_o  = bus_addr_q;
  assign bus.data_be_o    = be_q;
  assign bus.data_wdata_o = wdata_q;

endmodule

// File: tb/tb_lsu_store_bus.sv
// tb/tb_lsu_store_bus.sv - scoreboard bench for lsu_store_bus with a stalling/erroring memory responder
module tb_lsu_store_bus;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
  } txn_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic        st_sb;
  logic        st_sh;
  logic        st_done;
  logic        st_err;

  lsu_store_bus_if bus_if ();

  lsu_store_bus dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .st_valid_i (st_valid),
    .st_ready_o (st_ready),
    .st_addr_i  (st_addr),
    .st_wdata_i (st_wdata),
    .st_sb_i    (st_sb),
    .st_sh_i    (st_sh),
    .st_done_o  (st_done),
    .st_err_o   (st_err),
    .bus        (bus_if)
  );

  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int done_cnt = 0;
  int done_cyc = 0;

  int gnt_wait = 0;
  int rsp_wait = 1;
  int err_at   = 0;
  int store_id = 0;
  int poke_req = 0;

  txn_t     exp_txn_q[$];
  logic     exp_done_q[$];

  task automatic check_eq(input string tag, input logic [67:0] got, input logic [67:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Byte-by-byte placement model, independent of the shift-based datapath.
  function automatic void model(input logic [31:0] a, input logic [31:0] d, input logic sb,
                                input logic sh, input int gw, input int rw, input int ea,
                                input bit want_done, output int lat);
    int n;
    int off;
    int p;
    logic [3:0]  be0;
    logic [3:0]  be1;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] base;
    logic        split;
    logic        err;
    txn_t        t;
    n   = (sb && !sh) ? 1 : ((sh && !sb) ? 2 : 4);
    off = int'(a[1:0]);
    be0 = '0; be1 = '0; w0 = '0; w1 = '0;
    for (int i = 0; i < n; i++) begin
      p = off + i;
      if (p < 4) begin
        be0[p] = 1'b1;
        w0[8*p +: 8] = d[8*i +: 8];
      end else begin
        be1[p-4] = 1'b1;
        w1[8*(p-4) +: 8] = d[8*i +: 8];
      end
    end
    split = (be1 != 4'b0);
    base  = {a[31:2], 2'b00};
`ifdef MISALIGNED_SPLIT_EN
    t.a = base; t.be = be0; t.wd = w0;
    exp_txn_q.push_back(t);
    if (split && ea != 1) begin
      t.a = base + 32'd4; t.be = be1; t.wd = w1;
      exp_txn_q.push_back(t);
      lat = 2 * (1 + gw + rw);
    end else begin
      lat = 1 + gw + rw;
    end
    err = (ea == 1) || (split && ea == 2);
`else
    if (split) begin
      lat = 1;
      err = 1'b1;
    end else begin
      t.a = base; t.be = be0; t.wd = w0;
      exp_txn_q.push_back(t);
      lat = 1 + gw + rw;
      err = (ea == 1);
    end
`endif
    if (want_done) exp_done_q.push_back(err);
  endfunction

  always @(posedge clk_i) cyc++;

  // Memory responder: grants after gnt_wait cycles of request, answers rsp_wait cycles after grant.
  initial begin
    int gnt_cnt;
    int rsp_cnt;
    int rsp_num;
    int seen_id;
    int poke_seen;
    gnt_cnt = 0; rsp_cnt = 0; rsp_num = 0; seen_id = 0; poke_seen = 0;
    bus_if.data_gnt_i    = 1'b0;
    bus_if.data_rvalid_i = 1'b0;
    bus_if.data_err_i    = 1'b0;
    forever begin
      @(negedge clk_i);
      bus_if.data_gnt_i    = 1'b0;
      bus_if.data_rvalid_i = 1'b0;
      bus_if.data_err_i    = 1'b0;
      if (seen_id != store_id) begin
        seen_id = store_id;
        rsp_num = 0;
      end
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          rsp_num++;
          bus_if.data_rvalid_i = 1'b1;
          bus_if.data_err_i    = (rsp_num == err_at);
        end
      end
      if (poke_seen != poke_req) begin
        poke_seen = poke_req;
        bus_if.data_rvalid_i = 1'b1;
        bus_if.data_err_i    = 1'b1;
      end
      if (bus_if.data_req_o) begin
        if (gnt_cnt >= gnt_wait) begin
          bus_if.data_gnt_i = 1'b1;
          gnt_cnt = 0;
          rsp_cnt = rsp_wait;
        end else begin
          gnt_cnt++;
        end
      end else begin
        gnt_cnt = 0;
      end
    end
  end

  // Bus/completion monitor sampling mid-low-phase.
  initial begin
    bit          hold_v;
    logic [31:0] h_addr;
    logic [3:0]  h_be;
    logic [31:0] h_wd;
    txn_t        e;
    logic        ee;
    hold_v = 1'b0; h_addr = '0; h_be = '0; h_wd = '0;
    forever begin
      @(negedge clk_i);
      #2;
      check_eq("we_eq_req", 68'(bus_if.data_we_o), 68'(bus_if.data_req_o));
      if (!bus_if.data_req_o)
        check_eq("idle_bus", {bus_if.data_addr_o, bus_if.data_be_o, bus_if.data_wdata_o}, 68'b0);
      if (hold_v && bus_if.data_req_o)
        check_eq("hold_stable", {bus_if.data_addr_o, bus_if.data_be_o, bus_if.data_wdata_o},
                 {h_addr, h_be, h_wd});
      hold_v = bus_if.data_req_o && !bus_if.data_gnt_i;
      h_addr = bus_if.data_addr_o; h_be = bus_if.data_be_o; h_wd = bus_if.data_wdata_o;
      if (bus_if.data_req_o && bus_if.data_gnt_i) begin
        if (exp_txn_q.size() == 0) begin
          check_eq("txn_unexpected", 68'd1, 68'd0);
        end else begin
          e = exp_txn_q.pop_front();
          check_eq("txn_addr", 68'(bus_if.data_addr_o), 68'(e.a));
          check_eq("txn_be", 68'(bus_if.data_be_o), 68'(e.be));
          check_eq("txn_wdata", 68'(bus_if.data_wdata_o), 68'(e.wd));
        end
      end
      if (st_done) begin
        done_cnt++;
        done_cyc = cyc;
        if (exp_done_q.size() == 0) begin
          check_eq("done_unexpected", 68'd1, 68'd0);
        end else begin
          ee = exp_done_q.pop_front();
          check_eq("done_err", 68'(st_err), 68'(ee));
        end
      end else if (st_err) begin
        check_eq("err_without_done", 68'(st_err), 68'd0);
      end
    end
  end

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic sb,
                          input logic sh, input int gw, input int rw, input int ea);
    int lat;
    int t0;
    int dc0;
    bit got;
    gnt_wait = gw; rsp_wait = rw; err_at = ea; store_id++;
    model(a, d, sb, sh, gw, rw, ea, 1'b1, lat);
    @(negedge clk_i);
    st_valid = 1'b1; st_addr = a; st_wdata = d; st_sb = sb; st_sh = sh;
    t0 = cyc; dc0 = done_cnt;
    #1 check_eq("ready_idle", 68'(st_ready), 68'd1);
    @(negedge clk_i);
    st_valid = 1'b0;
    #3 check_eq("ready_busy", 68'(st_ready), 68'd0);
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (done_cnt != dc0) begin
        got = 1'b1;
        break;
      end
      @(negedge clk_i);
      #3;
    end
    check_eq("done_seen", 68'(got), 68'd1);
    if (got) begin
      check_eq("latency", 68'(done_cyc - t0), 68'(lat));
      @(negedge clk_i);
      #3 check_eq("ready_after", 68'(st_ready), 68'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [31:0] ra;
    logic [31:0] rd;
    int kind;
    rst_ni = 1'b0; st_valid = 1'b0; st_addr = '0; st_wdata = '0; st_sb = 1'b0; st_sh = 1'b0;
    repeat (3) @(negedge clk_i);
    #3;
    check_eq("rst_ready", 68'(st_ready), 68'd1);
    check_eq("rst_req", 68'(bus_if.data_req_o), 68'd0);
    check_eq("rst_done_err", 68'({st_done, st_err}), 68'd0);
    check_eq("rst_bus", {bus_if.data_addr_o, bus_if.data_be_o, bus_if.data_wdata_o}, 68'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    do_store(32'h0000_1000, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, 1, 0);
    do_store(32'h0000_1003, 32'h0000_00A5, 1'b1, 1'b0, 0, 1, 0);
    do_store(32'h0000_1002, 32'h0000_1234, 1'b0, 1'b1, 3, 1, 0);
    do_store(32'h0000_1003, 32'h1122_3344, 1'b0, 1'b0, 0, 1, 0);
    do_store(32'h0000_1003, 32'h1122_3344, 1'b0, 1'b0, 0, 1, 1);
    do_store(32'h0000_1001, 32'h5566_7788, 1'b0, 1'b0, 1, 2, 2);
    do_store(32'hFFFF_FFFE, 32'hCAFE_F00D, 1'b0, 1'b0, 0, 1, 0);
    do_store(32'h0000_2000, 32'h0BAD_0BAD, 1'b1, 1'b1, 0, 3, 1);
    for (int o = 0; o < 4; o++) begin
      do_store(32'h0000_4000 + 32'(o), 32'h0000_005A + 32'(o), 1'b1, 1'b0, 0, 1, 0);
      do_store(32'h0000_5000 + 32'(o), 32'h0000_A000 + 32'(o), 1'b0, 1'b1, 1, 1, 0);
    end
    for (int r = 0; r < 24; r++) begin
      ra = $urandom;
      rd = $urandom;
      kind = $urandom_range(0, 3);
      if (kind == 0) rd = rd & 32'h0000_00FF;
      if (kind == 1) rd = rd & 32'h0000_FFFF;
      do_store(ra, rd, (kind == 0) || (kind == 3), (kind == 1) || (kind == 3),
               $urandom_range(0, 2), $urandom_range(1, 3), $urandom_range(0, 4));
    end

    // Stray response while idle must not complete anything.
    poke_req++;
    repeat (3) @(negedge clk_i);
    #3 check_eq("stray_rvalid_ready", 68'(st_ready), 68'd1);

    // Reset while a request is waiting for grant.
    gnt_wait = 1000; rsp_wait = 1; err_at = 0; store_id++;
    @(negedge clk_i);
    st_valid = 1'b1; st_addr = 32'h0000_3000; st_wdata = 32'h1357_9BDF; st_sb = 1'b0; st_sh = 1'b0;
    @(negedge clk_i);
    st_valid = 1'b0;
    #3 check_eq("req1_req", 68'(bus_if.data_req_o), 68'd1);
    rst_ni = 1'b0;
    #1;
    check_eq("rst_req1_req", 68'(bus_if.data_req_o), 68'd0);
    check_eq("rst_req1_bus", {bus_if.data_addr_o, bus_if.data_be_o, bus_if.data_wdata_o}, 68'b0);
    check_eq("rst_req1_ready", 68'(st_ready), 68'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Reset while waiting for the response; the late response must be ignored.
    gnt_wait = 0; rsp_wait = 6; err_at = 0; store_id++;
    model(32'h0000_6000, 32'h2468_ACE0, 1'b0, 1'b0, 0, 6, 0, 1'b0, lat);
    @(negedge clk_i);
    st_valid = 1'b1; st_addr = 32'h0000_6000; st_wdata = 32'h2468_ACE0; st_sb = 1'b0; st_sh = 1'b0;
    @(negedge clk_i);
    st_valid = 1'b0;
    @(negedge clk_i);
    #3;
    check_eq("wait1_ready", 68'(st_ready), 68'd0);
    check_eq("wait1_req", 68'(bus_if.data_req_o), 68'd0);
    rst_ni = 1'b0;
    #1;
    check_eq("rst_wait1_ready", 68'(st_ready), 68'd1);
    check_eq("rst_wait1_done", 68'({st_done, st_err}), 68'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (8) @(negedge clk_i);
    #3 check_eq("post_rst_ready", 68'(st_ready), 68'd1);

    do_store(32'h0000_7004, 32'h0F0F_F0F0, 1'b0, 1'b0, 0, 1, 0);

    check_eq("txn_q_empty", 68'(exp_txn_q.size()), 68'd0);
    check_eq("done_q_empty", 68'(exp_done_q.size()), 68'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
